// File: rtl/fu_branch_pred.sv
// Set-associative branch target buffer with per-entry saturating direction counters.
// Combinational lookup for fetch, one registered resolved-branch update per cycle.
module fu_branch_pred #(
  parameter int SETS     = 64,
  parameter int WAYS     = 2,
  parameter int CTR_BITS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc_fetch,
  output logic        hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        clear,
  input  logic        stall
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam int VW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  logic [WAYS-1:0]     valid_q  [SETS];
  logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
  logic [31:0]         target_q [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_q    [SETS][WAYS];

  logic [IDX_W-1:0] fIdx, uIdx;
  logic [TAG_W-1:0] fTag, uTag;
  logic [WAYS-1:0]  fetchHitVec, updHitVec;
  logic             uHit, freeFound;
  logic [VW-1:0]    uHitWay, freeWay, victimWay, allocWay;
  logic [CTR_BITS-1:0] ctrInc_d, ctrDec_d;
  logic             unused_pcbits;

  assign fIdx = pc_fetch[IDX_W+1:2];
  assign fTag = pc_fetch[31:IDX_W+2];
  assign uIdx = update_pc[IDX_W+1:2];
  assign uTag = update_pc[31:IDX_W+2];
  assign unused_pcbits = ^{pc_fetch[1:0], update_pc[1:0]};

  always_comb begin
    hit         = 1'b0;
    pred_taken  = 1'b0;
    pred_target = 32'h0;
    fetchHitVec = '0;
    for (int w = 0; w < WAYS; w++) begin
      fetchHitVec[w] = valid_q[fIdx][w] && (tag_q[fIdx][w] == fTag);
      if (fetchHitVec[w]) begin
        hit         = 1'b1;
        pred_taken  = ctr_q[fIdx][w][CTR_BITS-1];
        pred_target = target_q[fIdx][w];
      end
    end
  end

  // Update-side match plus the lowest free way; a full set falls back to the victim pointer.
  always_comb begin
    updHitVec = '0;
    uHit      = 1'b0;
    uHitWay   = '0;
    freeFound = 1'b0;
    freeWay   = '0;
    for (int w = 0; w < WAYS; w++) begin
      updHitVec[w] = valid_q[uIdx][w] && (tag_q[uIdx][w] == uTag);
      if (updHitVec[w]) begin
        uHit    = 1'b1;
        uHitWay = VW'(w);
      end
      if (!freeFound && !valid_q[uIdx][w]) begin
        freeFound = 1'b1;
        freeWay   = VW'(w);
      end
    end
    allocWay = freeFound ? freeWay : victimWay;
    ctrInc_d = (ctr_q[uIdx][uHitWay] == CTR_MAX) ? CTR_MAX
                                                 : ctr_q[uIdx][uHitWay] + CTR_BITS'(1);
    ctrDec_d = (ctr_q[uIdx][uHitWay] == '0) ? '0
                                            : ctr_q[uIdx][uHitWay] - CTR_BITS'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          ctr_q[s][w]    <= '0;
        end
      end
    end else if (!stall) begin
      if (clear) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          for (int w = 0; w < WAYS; w++) ctr_q[s][w] <= '0;
        end
      end else if (update_valid) begin
        if (uHit) begin
          if (update_taken) begin
            ctr_q[uIdx][uHitWay]    <= ctrInc_d;
            target_q[uIdx][uHitWay] <= update_target;
          end else begin
            ctr_q[uIdx][uHitWay] <= ctrDec_d;
          end
        end else if (update_taken) begin
          valid_q[uIdx][allocWay]  <= 1'b1;
          tag_q[uIdx][allocWay]    <= uTag;
          target_q[uIdx][allocWay] <= update_target;
          ctr_q[uIdx][allocWay]    <= CTR_WEAK;
        end
      end
    end
  end

  // Round-robin victim only advances when a full set is forced to evict.
  if (WAYS > 1) begin : gVictim
    logic [VW-1:0] victim_q [SETS];
    assign victimWay = victim_q[uIdx];
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        for (int s = 0; s < SETS; s++) victim_q[s] <= '0;
      end else if (!stall) begin
        if (clear) begin
          for (int s = 0; s < SETS; s++) victim_q[s] <= '0;
        end else if (update_valid && update_taken && !uHit && !freeFound) begin
          victim_q[uIdx] <= victim_q[uIdx] + VW'(1);
        end
      end
    end
  end else begin : gNoVictim
    assign victimWay = '0;
  end

endmodule

// File: tb/tb_fu_branch_pred.sv
// Scoreboard bench for fu_branch_pred (SETS=64, WAYS=2, CTR_BITS=2): expected lookups
// are queued as stimulus is applied and compared when the combinational output settles.
module tb_fu_branch_pred;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] pc_fetch = 32'h0;
  logic        hit, pred_taken;
  logic [31:0] pred_target;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = 32'h0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = 32'h0;
  logic        clear = 1'b0;
  logic        stall = 1'b0;

  fu_branch_pred #(.SETS(64), .WAYS(2), .CTR_BITS(2)) dut (
    .CLK(CLK), .nRST(nRST), .pc_fetch(pc_fetch), .hit(hit),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .clear(clear), .stall(stall)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        eHit;
    logic        eTaken;
    logic [31:0] eTarget;
    string       tag;
  } expect_t;

  expect_t sbQueue[$];
  int vectorCount = 0;
  int miscompareCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic drainScoreboard();
    expect_t e;
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkOutput({e.tag, ".hit"},    {31'b0, hit},        {31'b0, e.eHit});
      checkOutput({e.tag, ".taken"},  {31'b0, pred_taken}, {31'b0, e.eTaken});
      checkOutput({e.tag, ".target"}, pred_target,         e.eTarget);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic eHit, input logic eTaken,
                               input logic [31:0] eTarget, input string tag);
    expect_t e;
    pc_fetch  = pc;
    e.eHit    = eHit;
    e.eTaken  = eTaken;
    e.eTarget = eTarget;
    e.tag     = tag;
    sbQueue.push_back(e);
    #1;
    drainScoreboard();
  endtask

  task automatic driveUpdate(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    update_valid  = 1'b1;
    update_pc     = pc;
    update_taken  = taken;
    update_target = tgt;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    update_valid = 1'b0;
    clear        = 1'b0;
    stall        = 1'b0;
    @(negedge CLK);
  endtask

  task automatic doUpdate(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    driveUpdate(pc, taken, tgt);
    tick();
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    applyStimulus(32'h100, 0, 0, 32'h0, "in_reset");
    @(negedge CLK);
    nRST = 1'b1;
    applyStimulus(32'h100, 0, 0, 32'h0, "after_reset");

    doUpdate(32'h100, 0, 32'h80);
    applyStimulus(32'h100, 0, 0, 32'h0, "nt_no_alloc");

    driveUpdate(32'h100, 1, 32'h80);
    applyStimulus(32'h100, 0, 0, 32'h0, "same_cycle");
    tick();
    applyStimulus(32'h100, 1, 1, 32'h80, "alloc");

    // Counter walk: 2 -> 3 (saturate) -> 0 (saturate) -> 1 -> 2
    doUpdate(32'h100, 1, 32'h80);
    doUpdate(32'h100, 1, 32'h80);
    doUpdate(32'h100, 1, 32'h84);
    applyStimulus(32'h100, 1, 1, 32'h84, "sat_hi");
    doUpdate(32'h100, 0, 32'hDEAD);
    applyStimulus(32'h100, 1, 1, 32'h84, "nt1");
    doUpdate(32'h100, 0, 32'hDEAD);
    applyStimulus(32'h100, 1, 0, 32'h84, "nt2");
    doUpdate(32'h100, 0, 32'hDEAD);
    applyStimulus(32'h100, 1, 0, 32'h84, "nt3");
    doUpdate(32'h100, 0, 32'hDEAD);
    applyStimulus(32'h100, 1, 0, 32'h84, "nt_floor");
    doUpdate(32'h100, 1, 32'h88);
    applyStimulus(32'h100, 1, 0, 32'h88, "t_from_floor");
    doUpdate(32'h100, 1, 32'h88);
    applyStimulus(32'h100, 1, 1, 32'h88, "t_weak");

    // Conflict eviction in set 0
    doUpdate(32'h200, 1, 32'h2000);
    doUpdate(32'h300, 1, 32'h3000);
    applyStimulus(32'h100, 0, 0, 32'h0,    "evict_100");
    applyStimulus(32'h200, 1, 1, 32'h2000, "keep_200");
    applyStimulus(32'h303, 1, 1, 32'h3000, "keep_300_lowbits");
    doUpdate(32'h400, 1, 32'h4000);
    applyStimulus(32'h200, 0, 0, 32'h0,    "evict_200");
    applyStimulus(32'h300, 1, 1, 32'h3000, "keep_300");
    applyStimulus(32'h400, 1, 1, 32'h4000, "keep_400");

    // Clear wins over a simultaneous update
    driveUpdate(32'h500, 1, 32'h5000);
    clear = 1'b1;
    tick();
    applyStimulus(32'h300, 0, 0, 32'h0, "clear_300");
    applyStimulus(32'h400, 0, 0, 32'h0, "clear_400");
    applyStimulus(32'h500, 0, 0, 32'h0, "clear_500");

    // Distinct indices with an identical tag
    doUpdate(32'h700, 1, 32'h7000);
    doUpdate(32'h704, 1, 32'h7040);
    applyStimulus(32'h700, 1, 1, 32'h7000, "idx0");
    applyStimulus(32'h704, 1, 1, 32'h7040, "idx1");

    // Stall freezes updates and clear
    repeat (2) begin
      driveUpdate(32'h700, 0, 32'h0);
      stall = 1'b1;
      tick();
    end
    applyStimulus(32'h700, 1, 1, 32'h7000, "stall_upd");
    driveUpdate(32'h600, 1, 32'h6000);
    stall = 1'b1;
    tick();
    applyStimulus(32'h600, 0, 0, 32'h0, "stall_alloc");
    clear = 1'b1;
    stall = 1'b1;
    tick();
    applyStimulus(32'h700, 1, 1, 32'h7000, "stall_clear");

    // Async reset between update edges, with an update still pending
    driveUpdate(32'h800, 1, 32'h8000);
    @(posedge CLK);
    applyStimulus(32'h800, 1, 1, 32'h8000, "pre_reset");
    nRST = 1'b0;
    applyStimulus(32'h800, 0, 0, 32'h0, "async_reset");
    @(negedge CLK);
    update_valid = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    applyStimulus(32'h800, 0, 0, 32'h0, "post_reset_800");
    applyStimulus(32'h700, 0, 0, 32'h0, "post_reset_700");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/fu_branch_pred.md
Name: fu_branch_pred

Overview:
Parametrised set-associative branch target buffer with per-entry saturating direction counters. It is the next generation of the fetch-stage BTB. Fetch looks up pc_fetch combinationally and gets hit, predicted direction and target. The branch FU writes back resolved outcome and target one update per cycle. Direction comes from an N-bit counter per entry instead of a backward-branch heuristic.

Parameters:
SETS, 64, number of sets; power of two, >= 2
WAYS, 2, associativity; power of two, 1..8
CTR_BITS, 2, width of the direction counter; >= 1
IDX_W, $clog2(SETS), derived index width
TAG_W, 32-IDX_W-2, derived tag width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
pc_fetch  in  32  fetch-stage PC to look up
hit  out  1  lookup matched a valid entry
pred_taken  out  1  predicted taken (hit & counter MSB)
pred_target  out  32  stored target on hit, else 0
update_valid  in  1  resolved branch write-back this cycle
update_pc  in  32  PC of resolved branch
update_taken  in  1  resolved direction
update_target  in  32  resolved target
clear  in  1  synchronous invalidate-all (context switch / flush)
stall  in  1  when high, update and clear are ignored (state frozen); lookup is unaffected

Behaviour:
- Address split, identical for pc_fetch and update_pc: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. pc[1:0] is ignored.
- Storage per set, for each way: valid, tag[TAG_W], target[32], ctr[CTR_BITS]. Per set: victim pointer [$clog2(WAYS)] (absent when WAYS=1).
- Reset (nRST=0, async): all valid=0, ctr=0, victim pointers=0. Outputs are therefore hit=0, pred_taken=0, pred_target=0.
- Lookup is purely combinational, 0-cycle latency. A way hits if valid and its tag equals the fetch tag. At most one way matches, because allocation never duplicates a tag in a set. On a miss, all outputs are 0.
- Updates are registered on the CLK rising edge. Lookup in the same cycle as an update sees the old state: no write-to-read bypass. The new state is visible the next cycle.
- Update when update_valid=1 and stall=0, with a way hit in the update set:
  - taken: ctr saturating +1 (max 2^CTR_BITS-1) and target <= update_target.
  - not taken: ctr saturating -1 (min 0); target unchanged.
  - tag and valid unchanged; victim pointer unchanged.
- Update on a miss:
  - not taken: no state change (no allocation).
  - taken: allocate a way. Choose the lowest-index invalid way if one exists; otherwise the way at the victim pointer, and the victim pointer increments mod WAYS.
  - Allocated way gets valid=1, tag, target=update_target, ctr=weakly taken (1<<(CTR_BITS-1)).
  - Allocation into an invalid way does not move the victim pointer.
- clear=1 and stall=0: next edge all valid=0, all ctr=0, victim pointers=0. clear has priority over a simultaneous update, which is dropped.
- stall=1: no state change regardless of update_valid or clear.
- Reset asserted mid-operation aborts any pending update. Every structure returns to reset values immediately.
- CTR_BITS=1: the counter is a last-outcome bit; allocation sets it to 1.

Test Plan:
- After reset, pc_fetch=0x0000_0100 -> hit=0, pred_taken=0, pred_target=0. Update pc=0x100, not taken -> next cycle still hit=0.
- Update pc=0x100 taken target=0x80 -> same cycle hit=0. Next cycle, pc_fetch=0x100 -> hit=1, pred_taken=1, pred_target=0x80.
- Counter saturation with CTR_BITS=2: from allocation (2), three taken updates -> ctr=3. Then three not-taken -> ctr=0, pred_taken=0, hit=1. A further not-taken keeps ctr=0. One taken -> ctr=1, pred_taken=0.
- Conflict eviction, SETS=64, WAYS=2: allocate taken at 0x100, 0x200 and 0x300 (all index 0) -> 0x100 evicted (hit=0), 0x200 and 0x300 hit. Allocate 0x400 -> 0x200 evicted.
- clear and update asserted together at pc=0x500 taken -> next cycle no PC hits, including 0x500. With stall=1 and update_valid=1 -> no change.
- Async reset asserted between two update edges -> outputs 0 without waiting for CLK. Previously allocated entries miss after release.
